// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Iterative signed 32x32 multiply / divide unit with HI/LO result registers.
// MULT uses radix-2 Booth recoding, one step per cycle. DIV uses restoring
// division on operand magnitudes, one quotient bit per cycle, with the signs
// fixed up when the result is written.
//
// Ports
//   clock     in   1   system clock, rising-edge active
//   reset     in   1   synchronous active-low reset
//   mult_div  in   2   command: 00 none, 01 signed MULT, 10 signed DIV, 11 ignored
//   a         in   32  multiplicand / dividend, captured on command acceptance
//   b         in   32  multiplier / divisor, captured on command acceptance
//   hi        out  32  product[63:32] or remainder
//   lo        out  32  product[31:0] or quotient
//   busy      out  1   high while iteration steps are in progress
//   done      out  1   one-cycle pulse when hi/lo are updated or a DIV aborts
//   div0      out  1   one-cycle pulse, with done, for DIV by zero
//
// Timing (acceptance edge = N): iteration steps happen on edges N+1..N+32,
// busy is high for the cycles after those edges, hi/lo are written on edge
// N+33 as the FSM enters FINISH, and FINISH (done) lasts one cycle.
// -----------------------------------------------------------------------------
module mult_div_unit (
   input  logic        clock,
   input  logic        reset,
   input  logic [1:0]  mult_div,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        busy,
   output logic        done,
   output logic        div0
);

   localparam logic [5:0] ITER_LAST = 6'd32;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_MULT   = 2'd1,
      S_DIV    = 2'd2,
      S_FINISH = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [5:0]         cnt;
   logic               accept;
   logic               iterate;
   logic               finish_op;

   // Booth datapath: 33-bit accumulator so that subtracting a multiplicand of
   // -2^31 cannot overflow.
   logic signed [32:0] acc;
   logic signed [32:0] mcand;
   logic [31:0]        mq;
   logic               q_m1;
   logic signed [32:0] booth_sum;

   // Restoring divider datapath on magnitudes
   logic [31:0]        dq;
   logic [31:0]        dm;
   logic [31:0]        rem;
   logic [32:0]        r_sh;
   logic [31:0]        r_sub;
   logic               r_ge;
   logic               q_neg;
   logic               r_neg;
   logic               is_div;

   function automatic logic [31:0] abs32(input logic [31:0] v);
      return v[31] ? (~v + 32'd1) : v;
   endfunction

   function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
      return neg ? (~v + 32'd1) : v;
   endfunction

   // State register
   always_ff @(posedge clock) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next state and step controls
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      iterate   = 1'b0;
      finish_op = 1'b0;
      case (state)
         S_IDLE: begin
            if (reset && (mult_div == 2'b01)) begin
               state_nxt = S_MULT;
               accept    = 1'b1;
            end else if (reset && (mult_div == 2'b10)) begin
               state_nxt = S_DIV;
               accept    = 1'b1;
            end
         end
         S_MULT: begin
            if (cnt == ITER_LAST) begin
               state_nxt = S_FINISH;
               finish_op = 1'b1;
            end else begin
               iterate = 1'b1;
            end
         end
         S_DIV: begin
            // A zero divisor is detected before the first step and skips
            // straight to FINISH without touching hi/lo.
            if ((cnt == 6'd0) && (dm == 32'd0)) begin
               state_nxt = S_FINISH;
            end else if (cnt == ITER_LAST) begin
               state_nxt = S_FINISH;
               finish_op = 1'b1;
            end else begin
               iterate = 1'b1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Booth step: recode {mq[0], q_m1}, add/subtract, arithmetic shift right
   always_comb begin
      case ({mq[0], q_m1})
         2'b01:   booth_sum = acc + mcand;
         2'b10:   booth_sum = acc - mcand;
         default: booth_sum = acc;
      endcase
   end

   // Restoring step: shift in the next dividend bit, subtract if it fits
   always_comb begin
      r_sh  = {rem, dq[31]};
      r_ge  = (r_sh >= {1'b0, dm});
      r_sub = r_sh[31:0] - dm;
   end

   // Control and architectural registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt <= 6'd0;
         hi  <= 32'd0;
         lo  <= 32'd0;
      end else begin
         if (accept)       cnt <= 6'd0;
         else if (iterate) cnt <= cnt + 6'd1;

         if (finish_op) begin
            if (is_div) begin
               hi <= cond_neg(rem, r_neg);
               lo <= cond_neg(dq, q_neg);
            end else begin
               hi <= acc[31:0];
               lo <= mq;
            end
         end
      end
   end

   // Iteration datapath (operands and partial results, no reset needed)
   always_ff @(posedge clock) begin
      if (accept) begin
         acc    <= '0;
         mcand  <= {a[31], a};
         mq     <= b;
         q_m1   <= 1'b0;
         dq     <= abs32(a);
         dm     <= abs32(b);
         rem    <= 32'd0;
         q_neg  <= a[31] ^ b[31];
         r_neg  <= a[31];
         is_div <= mult_div[1];
      end else if (iterate) begin
         if (is_div) begin
            rem <= r_ge ? r_sub : r_sh[31:0];
            dq  <= {dq[30:0], r_ge};
         end else begin
            acc  <= booth_sum >>> 1;
            mq   <= {booth_sum[0], mq[31:1]};
            q_m1 <= mq[0];
         end
      end
   end

   // busy excludes the acceptance cycle (cnt still 0) and FINISH
   assign busy = ((state == S_MULT) || (state == S_DIV)) && (cnt != 6'd0);
   assign done = (state == S_FINISH);
   assign div0 = (state == S_FINISH) && is_div && (dm == 32'd0);

endmodule
